// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sm4_pkg;

  localparam int SM4_WORD_W = 32;
  localparam int SM4_BYTE_W = 8;

  // Fibonacci LFSR taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [SM4_WORD_W-1:0] SM4_LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    TAU_IDLE,
    TAU_BUSY,
    TAU_DONE
  } tau_state_e;

  // A word in two Boolean shares: unmasked value = data ^ mask.
  typedef struct packed {
    logic [SM4_WORD_W-1:0] data;
    logic [SM4_WORD_W-1:0] mask;
  } sm4_masked_word_s;

  // One LFSR step: shift towards the MSB, feedback bit enters at bit 0.
  function automatic logic [SM4_WORD_W-1:0] lfsr_next(input logic [SM4_WORD_W-1:0] s);
    return {s[SM4_WORD_W-2:0], ^(s & SM4_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sbox.sv
// Masked SM4 S-box for one byte: o ^ m_o == SBox(i ^ m_i); output mask equals input mask.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module sbox (
  input  logic [7:0] i,
  input  logic [7:0] m_i,
  output logic [7:0] o,
  output logic [7:0] m_o
);

  localparam logic [7:0] SBOX_TABLE [0:255] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // Output mask reuses the input mask so the result stays in the same share domain.
  assign o   = SBOX_TABLE[i ^ m_i] ^ m_i;
  assign m_o = m_i;

endmodule

// File: rtl/sm4_mask_lfsr.sv
// Seeded 32-bit Fibonacci LFSR (taps 32,22,2,1) used to re-randomise mask shares.
// Latency: value changes one cycle after advance is sampled high.
// Backpressure: none; advances only when the owner accepts a word.
module sm4_mask_lfsr
  import sm4_pkg::*;
#(
  parameter logic [SM4_WORD_W-1:0] SEED = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  output logic [SM4_WORD_W-1:0] value
);

  // A non-zero seed keeps the register out of the all-zero lock-up state forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/sm4_tau_sched.sv
// Masked SM4 tau: four byte S-box lookups time-shared over SBOX_LANES sbox instances.
// Latency: accept to v_o = N+1 cycles (N = 4/SBOX_LANES); one word every N+2 cycles.
// Backpressure: result held in DONE until ready_i; no new word accepted until the cycle after handover.
// Optional mask refresh on capture is enabled by defining SM4_TAU_REFRESH_EN.
module sm4_tau_sched
  import sm4_pkg::*;
#(
  parameter int                    SBOX_LANES = 1,
  parameter logic [SM4_WORD_W-1:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic [SM4_WORD_W-1:0] data_i,
  input  logic [SM4_WORD_W-1:0] mask_i,
  output logic                  v_o,
  input  logic                  ready_i,
  output logic [SM4_WORD_W-1:0] data_o,
  output logic [SM4_WORD_W-1:0] mask_o
);

  localparam int         N        = 4 / SBOX_LANES;
  localparam logic [1:0] CNT_LAST = 2'(N - 1);

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("sm4_tau_sched: SBOX_LANES must be 1, 2 or 4");
  end

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("sm4_tau_sched: LFSR_SEED must be non-zero");
  end

  tau_state_e       state;
  logic [1:0]       cnt;
  sm4_masked_word_s work;
  sm4_masked_word_s capture;

  logic [SBOX_LANES-1:0][SM4_BYTE_W-1:0] lane_i;
  logic [SBOX_LANES-1:0][SM4_BYTE_W-1:0] lane_mi;
  logic [SBOX_LANES-1:0][SM4_BYTE_W-1:0] lane_o;
  logic [SBOX_LANES-1:0][SM4_BYTE_W-1:0] lane_mo;
  logic [1:0]                            lane_byte [SBOX_LANES];

  logic [SM4_WORD_W-1:0] res_data_nxt;
  logic [SM4_WORD_W-1:0] res_mask_nxt;

`ifdef SM4_TAU_REFRESH_EN
  logic                  accept;
  logic [SM4_WORD_W-1:0] lfsr_val;

  assign accept = v_i & ready_o & (state == TAU_IDLE);

  sm4_mask_lfsr #(
    .SEED (LFSR_SEED)
  ) u_mask_lfsr (
    .clk     (clk_i),
    .reset   (reset_i),
    .advance (accept),
    .value   (lfsr_val)
  );

  // XOR the same fresh word into both shares: the unmasked value is untouched.
  assign capture = '{data: data_i ^ lfsr_val, mask: mask_i ^ lfsr_val};
`else
  assign capture = '{data: data_i, mask: mask_i};
`endif

  // Route bytes cnt*L .. cnt*L+L-1 of both work shares to the lanes; lanes never mix bytes.
  always_comb begin
    for (int l = 0; l < SBOX_LANES; l++) begin
      lane_byte[l] = 2'(int'(cnt) * SBOX_LANES + l);
      lane_i[l]    = work.data[{lane_byte[l], 3'b000} +: SM4_BYTE_W];
      lane_mi[l]   = work.mask[{lane_byte[l], 3'b000} +: SM4_BYTE_W];
    end
  end

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    sbox u_sbox (
      .i   (lane_i[g]),
      .m_i (lane_mi[g]),
      .o   (lane_o[g]),
      .m_o (lane_mo[g])
    );
  end

  // Merge lane outputs into the byte positions they came from; other bytes keep their value.
  always_comb begin
    res_data_nxt = data_o;
    res_mask_nxt = mask_o;
    for (int l = 0; l < SBOX_LANES; l++) begin
      res_data_nxt[{lane_byte[l], 3'b000} +: SM4_BYTE_W] = lane_o[l];
      res_mask_nxt[{lane_byte[l], 3'b000} +: SM4_BYTE_W] = lane_mo[l];
    end
  end

  // Scheduler FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= TAU_IDLE;
      ready_o <= 1'b1;
      v_o     <= 1'b0;
      data_o  <= '0;
      mask_o  <= '0;
      work    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        TAU_IDLE: begin
          ready_o <= 1'b1;
          if (v_i && ready_o) begin
            work    <= capture;
            cnt     <= '0;
            ready_o <= 1'b0;
            state   <= TAU_BUSY;
          end
        end
        TAU_BUSY: begin
          data_o <= res_data_nxt;
          mask_o <= res_mask_nxt;
          // The counter stops at its last value; it is only cleared by the next capture.
          if (cnt == CNT_LAST) begin
            v_o   <= 1'b1;
            state <= TAU_DONE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        TAU_DONE: begin
          // ready_o rises together with the handover so it is visible the cycle after.
          if (ready_i) begin
            v_o     <= 1'b0;
            ready_o <= 1'b1;
            state   <= TAU_IDLE;
          end
        end
        default: begin
          v_o     <= 1'b0;
          ready_o <= 1'b1;
          state   <= TAU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_tau_sched.sv
// Self-checking bench for sm4_tau_sched with SBOX_LANES = 1, 2 and 4 side by side.
// Expected results come from a byte-table tau model and a plain LFSR model.
// Each instance has its own valid/ready so it can be exercised independently.
module tb_sm4_tau_sched;

  localparam int          NCFG = 3;
  localparam logic [31:0] SEED = 32'hACE1_2468;
`ifdef SM4_TAU_REFRESH_EN
  localparam bit REFRESH = 1'b1;
`else
  localparam bit REFRESH = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset;
  logic [NCFG-1:0]            v;
  logic [NCFG-1:0]            ready_in;
  logic [NCFG-1:0]            ready_out;
  logic [NCFG-1:0]            vout;
  logic [31:0]                din;
  logic [31:0]                min;
  logic [NCFG-1:0][31:0]      dout;
  logic [NCFG-1:0][31:0]      mout;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    sm4_tau_sched #(
      .SBOX_LANES (1 << g),
      .LFSR_SEED  (SEED)
    ) u_dut (
      .clk_i   (clk),
      .reset_i (reset),
      .v_i     (v[g]),
      .ready_o (ready_out[g]),
      .data_i  (din),
      .mask_i  (min),
      .v_o     (vout[g]),
      .ready_i (ready_in[g]),
      .data_o  (dout[g]),
      .mask_o  (mout[g])
    );
  end

  logic [7:0] ref_sbox [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_cyc;
  logic [31:0] lfsr_m [NCFG];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // tau = apply the SM4 S-box to each of the four bytes independently.
  function automatic logic [31:0] ref_tau(input logic [31:0] x);
    logic [31:0] y;
    for (int k = 0; k < 4; k++) y[8*k +: 8] = ref_sbox[x[8*k +: 8]];
    return y;
  endfunction

  // Shift left by one; new LSB is the XOR of stages 32, 22, 2 and 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic int busy_cycles(input int c);
    return 4 / (1 << c);
  endfunction

  task automatic reset_model();
    for (int c = 0; c < NCFG; c++) lfsr_m[c] = SEED;
  endtask

  // Present a word once the instance is ready; returns one negedge after the accept edge.
  task automatic drive_word(input int c, input logic [31:0] d, input logic [31:0] m,
                            output logic [31:0] r);
    int k;
    k = 0;
    while (!ready_out[c] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready_before_send", {31'b0, ready_out[c]}, 32'd1);
    din     = d;
    min     = m;
    v[c]    = 1'b1;
    acc_cyc = cyc;
    r         = lfsr_m[c];
    lfsr_m[c] = lfsr_step(lfsr_m[c]);
    @(negedge clk);
    v[c] = 1'b0;
  endtask

  // Poll for v_o counting cycles since the accept, then check both shares.
  task automatic wait_result(input int c, input logic [31:0] d, input logic [31:0] m,
                             input logic [31:0] r, input string tag);
    int          k;
    logic [31:0] x;
    x = d ^ m;
    k = 1;
    check_eq({tag, "_busy_ready"}, {31'b0, ready_out[c]}, 32'd0);
    while (!vout[c] && k < 20) begin
      if (m != 32'd0) check_eq({tag, "_leak"}, {31'b0, dout[c] == x}, 32'd0);
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_latency"}, k, busy_cycles(c) + 1);
    check_eq({tag, "_unmasked"}, dout[c] ^ mout[c], ref_tau(x));
    check_eq({tag, "_mask"}, mout[c], REFRESH ? (m ^ r) : m);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, m, r, saved_d, saved_m, unm1, msk1;
    int          prev;

    reset    = 1'b1;
    v        = '0;
    ready_in = '1;
    din      = '0;
    min      = '0;
    reset_model();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int c = 0; c < NCFG; c++) begin
      check_eq("reset_ready", {31'b0, ready_out[c]}, 32'd1);
      check_eq("reset_v", {31'b0, vout[c]}, 32'd0);
      check_eq("reset_data", dout[c], 32'd0);
      check_eq("reset_mask", mout[c], 32'd0);
    end

    // Known vector on the four-lane instance.
    drive_word(2, 32'h0001_0203, 32'h0, r);
    wait_result(2, 32'h0001_0203, 32'h0, r, "vec4");
    check_eq("vec4_tau", dout[2] ^ mout[2], 32'hD690_E9FE);
    if (!REFRESH) check_eq("vec4_data", dout[2], 32'hD690_E9FE);

    // Same value with a non-trivial mask on the single-lane instance.
    drive_word(0, 32'h0001_0203 ^ 32'h5A5A_5A5A, 32'h5A5A_5A5A, r);
    wait_result(0, 32'h0001_0203 ^ 32'h5A5A_5A5A, 32'h5A5A_5A5A, r, "vec1");
    check_eq("vec1_tau", dout[0] ^ mout[0], 32'hD690_E9FE);

    // Backpressure: hold the result for 10 cycles while a second word is offered.
    @(negedge clk);
    ready_in[0] = 1'b0;
    d = $urandom;
    m = $urandom;
    drive_word(0, d, m, r);
    wait_result(0, d, m, r, "bp");
    saved_d = dout[0];
    saved_m = mout[0];
    din  = ~d;
    min  = m;
    v[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_hold_v", {31'b0, vout[0]}, 32'd1);
      check_eq("bp_hold_data", dout[0], saved_d);
      check_eq("bp_hold_mask", mout[0], saved_m);
      check_eq("bp_hold_ready", {31'b0, ready_out[0]}, 32'd0);
    end
    v[0]        = 1'b0;
    ready_in[0] = 1'b1;
    @(negedge clk);
    check_eq("bp_release_v", {31'b0, vout[0]}, 32'd0);
    check_eq("bp_release_ready", {31'b0, ready_out[0]}, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("bp_second_not_taken_v", {31'b0, vout[0]}, 32'd0);
    check_eq("bp_second_not_taken_data", dout[0], saved_d);

    // Reset in the second BUSY cycle aborts the word.
    d = $urandom;
    m = $urandom;
    drive_word(0, d, m, r);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reset_model();
    check_eq("abort_v", {31'b0, vout[0]}, 32'd0);
    check_eq("abort_ready", {31'b0, ready_out[0]}, 32'd1);
    check_eq("abort_data", dout[0], 32'd0);
    check_eq("abort_mask", mout[0], 32'd0);
    repeat (6) @(negedge clk);
    check_eq("abort_no_partial", {31'b0, vout[0]}, 32'd0);
    d = $urandom;
    m = $urandom;
    drive_word(0, d, m, r);
    wait_result(0, d, m, r, "after_abort");

`ifdef SM4_TAU_REFRESH_EN
    // Same word twice: fresh mask each time, identical unmasked result.
    d = $urandom;
    m = $urandom;
    drive_word(0, d, m, r);
    wait_result(0, d, m, r, "refresh_a");
    unm1 = dout[0] ^ mout[0];
    msk1 = mout[0];
    drive_word(0, d, m, r);
    wait_result(0, d, m, r, "refresh_b");
    check_eq("refresh_mask_differs", {31'b0, mout[0] != msk1}, 32'd1);
    check_eq("refresh_same_value", dout[0] ^ mout[0], unm1);
`else
    unm1 = '0;
    msk1 = '0;
`endif

    // Back-to-back random traffic on every lane count, checking accept spacing.
    for (int c = 0; c < NCFG; c++) begin
      prev = -1;
      for (int w = 0; w < 100; w++) begin
        d = $urandom;
        m = $urandom;
        drive_word(c, d, m, r);
        if (w > 0) check_eq("spacing", acc_cyc - prev, busy_cycles(c) + 2);
        prev = acc_cyc;
        wait_result(c, d, m, r, "rand");
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
